ysyx_23060236_csr_unit: RTL and testbench
=========================================

// Module: ysyx_23060236_csr_unit
// PURPOSE
//  Machine-mode CSR unit, successor to the core's 4-register CSR file: full CSRRW/RS/RC ops,
//  mstatus MIE/MPIE stacking, timer interrupt (mie/mip), 64-bit mcycle/minstret counters.
//  Sits beside the EXU; reads are combinational, updates commit on the valid (commit) cycle.
//  Produces the trap/return redirect (jump/jump_en) for the IFU.
// PARAMETERS
//  XLEN        32            register width
//  CNT_W       64            mcycle/minstret width (33..64; high half = bits CNT_W-1:32)
//  MTVEC_RST   32'h0         mtvec reset value (bits [1:0] forced 0, direct mode only)
//  MVENDORID   32'h79737978  read-only mvendorid
//  MARCHID     32'h015fdf0c  read-only marchid
// PORTS
//  clock      in   1     core clock
//  reset      in   1     asynchronous, active-low reset (0 = in reset)
//  valid      in   1     instruction commits this cycle; no state update without it
//  csr_addr   in   12    CSR address (imm field)
//  csr_op     in   2     00 none, 01 write, 10 set (|=), 11 clear (&=~)
//  wdata      in   XLEN  rs1 / zimm operand
//  rdata      out  XLEN  old value of csr_addr (combinational)
//  inst_ecall in   1     ecall at commit
//  inst_mret  in   1     mret at commit
//  retire     in   1     instruction retires (minstret increment, qualified by valid)
//  epc        in   XLEN  PC of committing instruction
//  irq_timer  in   1     level timer interrupt request -> mip.MTIP
//  jump       out  XLEN  redirect target
//  jump_en    out  1     redirect this cycle
//  irq_taken  out  1     interrupt trap taken this cycle
// BEHAVIOUR
//  - Address map: mstatus 300, mie 304, mtvec 305, mepc 341, mcause 342, mip 344,
//    mcycle B00, minstret B02, mcycleh B80, minstreth B82, mvendorid F11, marchid F12.
//    Unmapped -> rdata 0, writes ignored. Read-only CSRs ignore writes.
//  - Reset: mstatus=32'h1800 (MPP=11, MIE=MPIE=0), mie=0, mtvec=MTVEC_RST, mepc=0,
//    mcause=0, counters=0. rdata/jump are combinational; jump_en=0, irq_taken=0 in reset.
//  - new = op01: wdata; op10: old|wdata; op11: old&~wdata. Written on clock edge when valid.
//    op10/op11 with wdata==0 perform no write (side-effect-free read).
//  - mstatus: only MIE[3], MPIE[7] writable; MPP[12:11] reads 11; other bits read 0.
//  - mie: only MTIE[7] writable. mip: MTIP[7] = irq_timer (registered each cycle), read-only.
//  - mepc bits [1:0] read 0. mcause stores bit31 + [5:0]; other bits read 0.
//  - Trap priority (evaluated only when valid), highest first:
//    1 interrupt: mstatus.MIE & mie.MTIE & mip.MTIP -> mepc<=epc, mcause<=32'h80000007,
//      MPIE<=MIE, MIE<=0, jump=mtvec, jump_en=1, irq_taken=1; csr op/ecall/mret suppressed.
//    2 ecall: mepc<=epc, mcause<=11, MPIE<=MIE, MIE<=0, jump=mtvec, jump_en=1.
//    3 mret: MIE<=MPIE, MPIE<=1, jump=mepc, jump_en=1.
//    4 csr_op != 00: register write as above.
//  - jump_en/jump/irq_taken combinational in the commit cycle; state updates next edge.
//  - Counters: mcycle +1 every cycle out of reset; minstret +1 when valid&retire.
//    A CSR write to a counter half wins over its increment that cycle (other half holds).
//    Wrap 2^CNT_W-1 -> 0 silently. rdata returns pre-increment value.
//  - reset asserted mid-operation: all state forced to reset values immediately (async).
// CONFIGURATION
//  YSYX_23060236_CSR_COUNTER_EN defined: mcycle/minstret(+h) implemented as above.
//  Not defined: counter registers absent, those addresses read 0 and ignore writes,
//  retire unused; all other behaviour unchanged.
// TESTING
//  1 reset low then high; read 300 -> 32'h00001800, read F11 -> 32'h79737978, jump_en=0.
//  2 op01 305<=32'h80000003, then ecall epc=32'h80000100 -> jump=32'h80000000,
//    next cycle read 341 -> 32'h80000100, read 342 -> 32'hB.
//  3 op10 300 wdata=8 (MIE=1), op10 304 wdata=80, irq_timer=1, valid=1 ->
//    irq_taken=1, jump=mtvec; then read 342 -> 32'h80000007, read 300 -> 32'h1880.
//  4 after 3, mret -> jump=mepc; next read 300 -> 32'h1888; with MIE=0 irq_timer=1 -> no trap.
//  5 ecall and op01 341 same valid cycle -> mepc=epc (CSR write dropped);
//    valid=0 with ecall -> no state change, jump_en=0.
//  6 (COUNTER_EN) op01 B00<=32'hFFFFFFFF, B80<=32'hFFFFFFFF -> one cycle later mcycle
//    reads 0, mcycleh reads 0 (wrap); 3 valid&retire -> minstret +3.

Source files
------------

// File: rtl/ysyx_23060236_csr_unit_if.sv
// CSR unit commit-side bus: EXU (master) presents the committing instruction's
// CSR/trap request, the CSR unit (slave) returns read data and the IFU redirect.
interface ysyx_23060236_csr_unit_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            inst_ecall;
  logic            inst_mret;
  logic            retire;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] jump;
  logic            jump_en;
  logic            irq_taken;

  modport master (
    output valid, csr_addr, csr_op, wdata, inst_ecall, inst_mret, retire, epc,
    input  rdata, jump, jump_en, irq_taken
  );

  modport slave (
    input  valid, csr_addr, csr_op, wdata, inst_ecall, inst_mret, retire, epc,
    output rdata, jump, jump_en, irq_taken
  );
endinterface

// File: rtl/ysyx_23060236_csr_unit.sv
// Machine-mode CSR unit: CSRRW/RS/RC, mstatus MIE/MPIE stacking, timer
// interrupt through mie/mip, ecall/mret redirect for the IFU.
// Define YSYX_23060236_CSR_COUNTER_EN to build the mcycle/minstret counters;
// without it their addresses read 0 and ignore writes.
module ysyx_23060236_csr_unit #(
  parameter int          XLEN      = 32,
  parameter int          CNT_W     = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0,
  parameter logic [31:0] MVENDORID = 32'h79737978,
  parameter logic [31:0] MARCHID   = 32'h015fdf0c
) (
  input logic                     clock,
  input logic                     reset,
  input logic                     irq_timer,
  ysyx_23060236_csr_unit_if.slave bus
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;

  localparam int HI_W = CNT_W - 32;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  // Architectural state: only the implemented bits are stored.
  logic            st_mie;
  logic            st_mpie;
  logic            mie_mtie;
  logic            mip_mtip;
  logic [XLEN-1:2] mtvec_q;
  logic [XLEN-1:2] mepc_q;
  logic            mcause_int;
  logic [5:0]      mcause_code;

  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic            take_irq;
  logic            take_ecall;
  logic            take_mret;
  logic            csr_wr;
  logic            unused_in;

`ifdef YSYX_23060236_CSR_COUNTER_EN
  logic [CNT_W-1:0] mcycle_q;
  logic [CNT_W-1:0] minstret_q;
  logic [XLEN-1:0]  mcycle_hi;
  logic [XLEN-1:0]  minstret_hi;

  // Zero-extend the counter high halves to a full register width.
  always_comb begin
    mcycle_hi                = '0;
    minstret_hi              = '0;
    mcycle_hi[HI_W-1:0]      = mcycle_q[CNT_W-1:32];
    minstret_hi[HI_W-1:0]    = minstret_q[CNT_W-1:32];
  end

  assign unused_in = ^bus.epc[1:0];
`else
  assign unused_in = ^{bus.epc[1:0], bus.retire};
`endif

  // Combinational read of the addressed CSR (old value for read-modify-write).
  always_comb begin
    // NOTE: default first so every path assigns old_val and no latch is inferred.
    old_val = '0;
    case (bus.csr_addr)
      A_MSTATUS:   old_val = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      A_MIE:       old_val = {24'b0, mie_mtie, 7'b0};
      A_MTVEC:     old_val = {mtvec_q, 2'b00};
      A_MEPC:      old_val = {mepc_q, 2'b00};
      A_MCAUSE:    old_val = {mcause_int, 25'b0, mcause_code};
      A_MIP:       old_val = {24'b0, mip_mtip, 7'b0};
      A_MVENDORID: old_val = MVENDORID;
      A_MARCHID:   old_val = MARCHID;
`ifdef YSYX_23060236_CSR_COUNTER_EN
      A_MCYCLE:    old_val = mcycle_q[31:0];
      A_MCYCLEH:   old_val = mcycle_hi;
      A_MINSTRET:  old_val = minstret_q[31:0];
      A_MINSTRETH: old_val = minstret_hi;
`endif
      default:     old_val = '0;
    endcase
  end

  // Read-modify-write operand for the CSR instruction.
  always_comb begin
    new_val = old_val;
    case (csr_op_e'(bus.csr_op))
      OP_WRITE: new_val = bus.wdata;
      OP_SET:   new_val = old_val | bus.wdata;
      OP_CLEAR: new_val = old_val & ~bus.wdata;
      default:  new_val = old_val;
    endcase
  end

  // Commit-cycle priority: interrupt, ecall, mret, then the CSR write.
  // Set/clear with a zero operand is a pure read and must not write.
  assign take_irq   = bus.valid & st_mie & mie_mtie & mip_mtip;
  assign take_ecall = bus.valid & bus.inst_ecall & ~take_irq;
  assign take_mret  = bus.valid & bus.inst_mret & ~take_irq & ~take_ecall;
  assign csr_wr     = bus.valid & (bus.csr_op != OP_NONE)
                    & ~(bus.csr_op[1] & (bus.wdata == '0))
                    & ~take_irq & ~take_ecall & ~take_mret;

  assign bus.rdata     = old_val;
  assign bus.jump      = take_mret ? {mepc_q, 2'b00} : {mtvec_q, 2'b00};
  assign bus.jump_en   = reset & (take_irq | take_ecall | take_mret);
  assign bus.irq_taken = reset & take_irq;

  // Trap entry/return and CSR writes to the status/trap registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_mie      <= 1'b0;
      st_mpie     <= 1'b0;
      mie_mtie    <= 1'b0;
      mip_mtip    <= 1'b0;
      mtvec_q     <= MTVEC_RST[XLEN-1:2];
      mepc_q      <= '0;
      mcause_int  <= 1'b0;
      mcause_code <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, e.g. MPIE<=MIE.
      mip_mtip <= irq_timer;
      if (take_irq || take_ecall) begin
        mepc_q      <= bus.epc[XLEN-1:2];
        mcause_int  <= take_irq;
        mcause_code <= take_irq ? 6'd7 : 6'd11;
        st_mpie     <= st_mie;
        st_mie      <= 1'b0;
      end else if (take_mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (csr_wr) begin
        case (bus.csr_addr)
          A_MSTATUS: begin
            st_mie  <= new_val[3];
            st_mpie <= new_val[7];
          end
          A_MIE:    mie_mtie <= new_val[7];
          A_MTVEC:  mtvec_q  <= new_val[XLEN-1:2];
          A_MEPC:   mepc_q   <= new_val[XLEN-1:2];
          A_MCAUSE: begin
            mcause_int  <= new_val[31];
            mcause_code <= new_val[5:0];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef YSYX_23060236_CSR_COUNTER_EN
  // Free-running counters; a write to one half replaces that half and holds the other.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (csr_wr && bus.csr_addr == A_MCYCLE) begin
        mcycle_q[31:0] <= new_val;
      end else if (csr_wr && bus.csr_addr == A_MCYCLEH) begin
        mcycle_q[CNT_W-1:32] <= new_val[HI_W-1:0];
      end else begin
        mcycle_q <= mcycle_q + CNT_W'(1);
      end

      if (csr_wr && bus.csr_addr == A_MINSTRET) begin
        minstret_q[31:0] <= new_val;
      end else if (csr_wr && bus.csr_addr == A_MINSTRETH) begin
        minstret_q[CNT_W-1:32] <= new_val[HI_W-1:0];
      end else if (bus.valid && bus.retire) begin
        minstret_q <= minstret_q + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060236_csr_unit.sv
// Self-checking bench for ysyx_23060236_csr_unit: directed trap/CSR scenarios
// followed by randomized commits, all compared against a behavioural model.
module tb_ysyx_23060236_csr_unit;
  logic clock = 1'b0;
  logic reset;
  logic irq_timer;

  ysyx_23060236_csr_unit_if #(.XLEN(32)) bus ();

  ysyx_23060236_csr_unit dut (
    .clock     (clock),
    .reset     (reset),
    .irq_timer (irq_timer),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state (architectural view of each CSR).
  logic        m_st_mie, m_st_mpie, m_mtie, m_mtip;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  logic [63:0] m_mcycle, m_minstret;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | {24'b0, m_st_mpie, 3'b0, m_st_mie, 3'b0};
      12'h304: return {24'b0, m_mtie, 7'b0};
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return {24'b0, m_mtip, 7'b0};
      12'hF11: return 32'h79737978;
      12'hF12: return 32'h015fdf0c;
`ifdef YSYX_23060236_CSR_COUNTER_EN
      12'hB00: return m_mcycle[31:0];
      12'hB80: return m_mcycle[63:32];
      12'hB02: return m_minstret[31:0];
      12'hB82: return m_minstret[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_st_mie = 0; m_st_mpie = 0; m_mtie = 0; m_mtip = 0;
    m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mcycle = 0; m_minstret = 0;
  endtask

  // Apply one clock edge of architectural behaviour using the driven inputs.
  task automatic m_commit();
    logic        irq, ec, mr, wr, cyc_w, ins_w;
    logic [31:0] oldv, nv;
    logic [11:0] a;
    a     = bus.csr_addr;
    oldv  = m_read(a);
    irq   = bus.valid && m_st_mie && m_mtie && m_mtip;
    ec    = bus.valid && bus.inst_ecall && !irq;
    mr    = bus.valid && bus.inst_mret && !irq && !ec;
    wr    = bus.valid && bus.csr_op != 2'b00 && !irq && !ec && !mr
            && !(bus.csr_op != 2'b01 && bus.wdata == 32'h0);
    case (bus.csr_op)
      2'b01:   nv = bus.wdata;
      2'b10:   nv = oldv | bus.wdata;
      default: nv = oldv & ~bus.wdata;
    endcase
    cyc_w = 0;
    ins_w = 0;
    if (irq || ec) begin
      m_mepc    = bus.epc & 32'hFFFF_FFFC;
      m_mcause  = irq ? 32'h8000_0007 : 32'd11;
      m_st_mpie = m_st_mie;
      m_st_mie  = 0;
    end else if (mr) begin
      m_st_mie  = m_st_mpie;
      m_st_mpie = 1;
    end else if (wr) begin
      case (a)
        12'h300: begin m_st_mie = nv[3]; m_st_mpie = nv[7]; end
        12'h304: m_mtie   = nv[7];
        12'h305: m_mtvec  = nv & 32'hFFFF_FFFC;
        12'h341: m_mepc   = nv & 32'hFFFF_FFFC;
        12'h342: m_mcause = nv & 32'h8000_003F;
`ifdef YSYX_23060236_CSR_COUNTER_EN
        12'hB00: begin m_mcycle[31:0]    = nv; cyc_w = 1; end
        12'hB80: begin m_mcycle[63:32]   = nv; cyc_w = 1; end
        12'hB02: begin m_minstret[31:0]  = nv; ins_w = 1; end
        12'hB82: begin m_minstret[63:32] = nv; ins_w = 1; end
`endif
        default: ;
      endcase
    end
`ifdef YSYX_23060236_CSR_COUNTER_EN
    if (!cyc_w) m_mcycle = m_mcycle + 64'd1;
    if (!ins_w && bus.valid && bus.retire) m_minstret = m_minstret + 64'd1;
`endif
    m_mtip = irq_timer;
  endtask

  task automatic drive(input logic v, input logic [11:0] a, input logic [1:0] op,
                       input logic [31:0] wd, input logic ec, input logic mr,
                       input logic rt, input logic [31:0] pc);
    bus.valid = v; bus.csr_addr = a; bus.csr_op = op; bus.wdata = wd;
    bus.inst_ecall = ec; bus.inst_mret = mr; bus.retire = rt; bus.epc = pc;
  endtask

  // Compare all outputs against the model on the falling edge.
  task automatic sample(input string tag);
    logic ex_irq, ex_ec, ex_mr, ex_en;
    @(negedge clock);
    ex_irq = reset && bus.valid && m_st_mie && m_mtie && m_mtip;
    ex_ec  = reset && bus.valid && bus.inst_ecall && !ex_irq;
    ex_mr  = reset && bus.valid && bus.inst_mret && !ex_irq && !ex_ec;
    ex_en  = ex_irq || ex_ec || ex_mr;
    check({tag, ".rdata"}, bus.rdata, m_read(bus.csr_addr));
    check({tag, ".jump_en"}, bus.jump_en, ex_en);
    check({tag, ".irq_taken"}, bus.irq_taken, ex_irq);
    if (ex_en) check({tag, ".jump"}, bus.jump, ex_mr ? m_mepc : m_mtvec);
  endtask

  task automatic advance();
    @(posedge clock);
    if (reset) m_commit(); else m_reset();
    #1;
  endtask

  task automatic step(input string tag);
    sample(tag);
    advance();
  endtask

  task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                     input string tag);
    drive(1, a, op, wd, 0, 0, 0, 32'h0);
    step(tag);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    drive(0, a, 2'b00, 32'h0, 0, 0, 0, 32'h0);
    sample(tag);
    check({tag, ".exp"}, bus.rdata, exp);
    advance();
  endtask

  logic [11:0] addrs [13] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                              12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12,
                              12'h7C0};

  initial begin
    logic [63:0] ins_before;
    reset     = 0;
    irq_timer = 0;
    m_reset();
    // 1: reset state; an ecall during reset must not redirect.
    drive(1, 12'h300, 2'b00, 32'h0, 1, 0, 0, 32'h1234);
    step("rst_ecall");
    check("rst.jump_en", bus.jump_en, 1'b0);
    drive(0, 12'h300, 2'b00, 32'h0, 0, 0, 0, 32'h0);
    step("rst_hold");
    reset = 1;
    rd(12'h300, 32'h0000_1800, "t1.mstatus");
    rd(12'hF11, 32'h7973_7978, "t1.mvendorid");
    rd(12'h341, 32'h0, "t1.mepc");
    check("t1.jump_en", bus.jump_en, 1'b0);

    // 2: mtvec write, then ecall redirects to the aligned base.
    csr(12'h305, 2'b01, 32'h8000_0003, "t2.wr_mtvec");
    drive(1, 12'h305, 2'b00, 32'h0, 1, 0, 1, 32'h8000_0100);
    sample("t2.ecall");
    check("t2.jump", bus.jump, 32'h8000_0000);
    check("t2.jump_en", bus.jump_en, 1'b1);
    advance();
    rd(12'h341, 32'h8000_0100, "t2.mepc");
    rd(12'h342, 32'h0000_000B, "t2.mcause");

    // 3: enable MIE/MTIE, raise the timer, take the interrupt.
    csr(12'h300, 2'b10, 32'h8, "t3.set_mie");
    csr(12'h304, 2'b10, 32'h80, "t3.set_mtie");
    irq_timer = 1;
    drive(0, 12'h344, 2'b00, 32'h0, 0, 0, 0, 32'h0);
    step("t3.mip_latch");
    drive(1, 12'h304, 2'b01, 32'h0, 1, 0, 0, 32'h8000_0200);
    sample("t3.irq");
    check("t3.irq_taken", bus.irq_taken, 1'b1);
    check("t3.jump", bus.jump, 32'h8000_0000);
    advance();
    rd(12'h342, 32'h8000_0007, "t3.mcause");
    rd(12'h300, 32'h0000_1880, "t3.mstatus");
    rd(12'h304, 32'h0000_0080, "t3.mie_kept");

    // 4: mret returns to mepc and restores MIE; with MIE=0 no trap.
    drive(1, 12'h300, 2'b00, 32'h0, 0, 1, 1, 32'h0);
    sample("t4.mret");
    check("t4.jump", bus.jump, 32'h8000_0200);
    check("t4.jump_en", bus.jump_en, 1'b1);
    advance();
    rd(12'h300, 32'h0000_1888, "t4.mstatus");
    irq_timer = 0;
    rd(12'h344, 32'h0000_0080, "t4.mip_before_drop");
    csr(12'h300, 2'b11, 32'h8, "t4.clr_mie");
    irq_timer = 1;
    rd(12'h300, 32'h0000_1880, "t4.mie_off");
    drive(1, 12'h341, 2'b00, 32'h0, 0, 0, 1, 32'h8000_0300);
    sample("t4.no_trap");
    check("t4.no_jump", bus.jump_en, 1'b0);
    check("t4.no_irq", bus.irq_taken, 1'b0);
    advance();
    irq_timer = 0;

    // 5: ecall beats a same-cycle CSR write; valid=0 blocks everything.
    drive(1, 12'h341, 2'b01, 32'h1234_5678, 1, 0, 0, 32'h8000_0400);
    step("t5.ecall_wr");
    rd(12'h341, 32'h8000_0400, "t5.mepc");
    drive(0, 12'h342, 2'b01, 32'h3, 1, 0, 0, 32'h8000_0500);
    sample("t5.invalid");
    check("t5.jump_en", bus.jump_en, 1'b0);
    advance();
    rd(12'h342, 32'h0000_000B, "t5.mcause");
    rd(12'h341, 32'h8000_0400, "t5.mepc_kept");
    csr(12'hF11, 2'b01, 32'h0, "t5.ro_write");
    rd(12'hF11, 32'h7973_7978, "t5.ro_kept");
    csr(12'h342, 2'b10, 32'h0, "t5.set_zero");

`ifdef YSYX_23060236_CSR_COUNTER_EN
    // 6: counter wrap and minstret increments.
    csr(12'hB00, 2'b01, 32'hFFFF_FFFF, "t6.wr_lo");
    csr(12'hB80, 2'b01, 32'hFFFF_FFFF, "t6.wr_hi");
    drive(0, 12'hB00, 2'b00, 32'h0, 0, 0, 0, 32'h0);
    step("t6.all_ones");
    rd(12'hB00, 32'h0, "t6.mcycle_wrap");
    rd(12'hB80, 32'h0, "t6.mcycleh_wrap");
    ins_before = m_minstret;
    for (int i = 0; i < 3; i++) begin
      drive(1, 12'h300, 2'b00, 32'h0, 0, 0, 1, 32'h0);
      step("t6.retire");
    end
    rd(12'hB02, ins_before[31:0] + 32'd3, "t6.minstret");
`else
    ins_before = 64'd0;
    rd(12'hB00, 32'h0, "t6.no_mcycle");
    csr(12'hB02, 2'b01, 32'h55, "t6.wr_absent");
    rd(12'hB02, 32'h0 + ins_before[31:0], "t6.no_minstret");
`endif

    // Asynchronous reset mid-cycle clears state immediately.
    csr(12'h300, 2'b01, 32'h88, "ar.set");
    drive(1, 12'h300, 2'b00, 32'h0, 1, 0, 0, 32'h4);
    #2;
    reset = 0;
    #1;
    check("ar.mstatus", bus.rdata, 32'h0000_1800);
    check("ar.jump_en", bus.jump_en, 1'b0);
    m_reset();
    step("ar.hold");
    reset = 1;
    rd(12'h305, 32'h0, "ar.mtvec");

    // Randomized commits against the model.
    for (int i = 0; i < 400; i++) begin
      int k;
      k = $urandom_range(0, 12);
      drive($urandom_range(0, 3) != 0, addrs[k], 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            1'($urandom_range(0, 1)), $urandom);
      irq_timer = $urandom_range(0, 2) != 0;
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
